// File: rtl/speed_ctrl_pkg.sv
// Shared types for the pushbutton speed controller: FSM states, key indices
// and the owner (key currently driving the pulse stream).
package speed_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_FIRE         = 3'd1,
        ST_HOLD_DELAY   = 3'd2,
        ST_HOLD_REPEAT  = 3'd3,
        ST_WAIT_RELEASE = 3'd4
    } state_t;

    typedef logic [1:0] owner_t;

    localparam owner_t KEY_UP   = 2'd0;
    localparam owner_t KEY_DOWN = 2'd1;
    localparam owner_t KEY_RST  = 2'd2;

    function automatic logic [2:0] owner_onehot(input owner_t o);
        owner_onehot = 3'b001 << o;
    endfunction

    // Restore-default wins, then faster, then slower.
    function automatic owner_t pick_owner(input logic [2:0] deb);
        if (deb[KEY_RST])
            pick_owner = KEY_RST;
        else if (deb[KEY_UP])
            pick_owner = KEY_UP;
        else
            pick_owner = KEY_DOWN;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// One pushbutton: 2-flop synchronizer, consecutive-cycle debounce counter,
// debounced level and a one-cycle rising-edge strobe.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 32
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_key_n,
    output logic o_deb,
    output logic o_press
);

    localparam logic [CNT_W-1:0] L_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_meta;
    logic             r_sync_n;
    logic             r_deb;
    logic             r_deb_q;
    logic [CNT_W-1:0] r_cnt;
    logic             w_sync;

    assign w_sync = ~r_sync_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta   <= 1'b1;
            r_sync_n <= 1'b1;
            r_deb    <= 1'b0;
            r_deb_q  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_meta   <= i_key_n;
            r_sync_n <= r_meta;
            r_deb_q  <= r_deb;
            if (w_sync == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == L_TC) begin
                // Nth consecutive differing cycle: accept the new level.
                r_deb <= w_sync;
                r_cnt <= '0;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_deb   = r_deb;
    assign o_press = r_deb & ~r_deb_q;

endmodule

// File: rtl/speed_key_controller.sv
// Pushbuttons to single-cycle speed commands: arbitration, one pulse per
// press, auto-repeat while a step key is held, restore-default preemption.
//
// state           | meaning
// ST_IDLE         | no key owns the output, waiting for a press
// ST_FIRE         | owner's output pulses this cycle
// ST_HOLD_DELAY   | step key held, waiting for first auto-repeat
// ST_HOLD_REPEAT  | step key held, repeating every REPEAT_PERIOD
// ST_WAIT_RELEASE | waiting for every key to be released
module speed_key_controller
    import speed_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int CNT_W           = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] key_n,
    output logic       speed_up,
    output logic       speed_down,
    output logic       speed_reset,
    output logic [2:0] state_dbg
);

    // Counter restarts on entering each hold state, so the terminal counts
    // absorb the FIRE cycle and the entry cycle.
    localparam logic [CNT_W-1:0] L_DELAY_TC  = CNT_W'(REPEAT_DELAY - 2);
    localparam logic [CNT_W-1:0] L_PERIOD_TC = CNT_W'(REPEAT_PERIOD - 1);

    logic [2:0]       w_deb;
    logic [2:0]       w_press;

    state_t           r_state;
    state_t           w_state_nxt;
    owner_t           r_owner;
    owner_t           w_owner_nxt;
    logic [CNT_W-1:0] r_rpt_cnt;
    logic [CNT_W-1:0] w_rpt_nxt;
    logic [CNT_W-1:0] w_rpt_inc;
    logic [2:0]       r_pulse;
    logic [2:0]       w_pulse;

    for (genvar g = 0; g < 3; g++) begin : g_key
        key_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_key_debouncer (
            .clk     (clk),
            .reset_n (reset_n),
            .i_key_n (key_n[g]),
            .o_deb   (w_deb[g]),
            .o_press (w_press[g])
        );
    end

    assign w_rpt_inc = (r_rpt_cnt == '1) ? r_rpt_cnt : r_rpt_cnt + CNT_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_rpt_nxt   = '0;
        w_pulse     = 3'b000;
        case (r_state)
            ST_IDLE: begin
                if (|w_press) begin
                    w_owner_nxt = pick_owner(w_deb);
                    w_pulse     = owner_onehot(w_owner_nxt);
                    w_state_nxt = ST_FIRE;
                end
            end
            ST_FIRE: begin
                w_state_nxt = (r_owner == KEY_RST) ? ST_WAIT_RELEASE : ST_HOLD_DELAY;
            end
            ST_HOLD_DELAY, ST_HOLD_REPEAT: begin
                if (!w_deb[r_owner]) begin
                    w_state_nxt = (w_deb == 3'b000) ? ST_IDLE : ST_WAIT_RELEASE;
                end else if (w_press[KEY_RST] && (r_owner != KEY_RST)) begin
                    w_owner_nxt = KEY_RST;
                    w_pulse     = owner_onehot(KEY_RST);
                    w_state_nxt = ST_FIRE;
                end else if (r_rpt_cnt == ((r_state == ST_HOLD_DELAY) ? L_DELAY_TC : L_PERIOD_TC)) begin
                    w_pulse     = owner_onehot(r_owner);
                    w_state_nxt = ST_HOLD_REPEAT;
                end else begin
                    w_rpt_nxt   = w_rpt_inc;
                end
            end
            ST_WAIT_RELEASE: begin
                if (w_deb == 3'b000)
                    w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_owner   <= KEY_UP;
            r_rpt_cnt <= '0;
            r_pulse   <= 3'b000;
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_rpt_cnt <= w_rpt_nxt;
            r_pulse   <= w_pulse;
        end
    end

    assign speed_up    = r_pulse[KEY_UP];
    assign speed_down  = r_pulse[KEY_DOWN];
    assign speed_reset = r_pulse[KEY_RST];
    assign state_dbg   = r_state;

endmodule

// File: tb/tb_speed_key_controller.sv
// Bench for speed_key_controller: directed scenarios plus random key traffic,
// every cycle compared against a timestamp-based behavioural model.
module tb_speed_key_controller;

    localparam int D  = 4;
    localparam int R  = 10;
    localparam int PD = 3;

    localparam int M_IDLE = 0;
    localparam int M_FIRE = 1;
    localparam int M_HOLD = 2;
    localparam int M_WAIT = 3;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] key_n   = 3'b111;
    logic       speed_up;
    logic       speed_down;
    logic       speed_reset;
    logic [2:0] state_dbg;

    always #5 clk = ~clk;

    speed_key_controller #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (R),
        .REPEAT_PERIOD   (PD),
        .CNT_W           (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_n       (key_n),
        .speed_up    (speed_up),
        .speed_down  (speed_down),
        .speed_reset (speed_reset),
        .state_dbg   (state_dbg)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int c_up   = 0;
    int c_down = 0;
    int c_rst  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: raw-key delay line, run-length debounce, and a
    // hold timer expressed as elapsed edges since the last FIRE.
    logic [2:0] m_s1, m_s2, m_deb, m_debq, m_out, m_state;
    int         m_run [3];
    int         m_mode, m_owner, m_fire, m_edge;

    task automatic model_reset();
        m_s1 = 3'b111; m_s2 = 3'b111; m_deb = 3'b000; m_debq = 3'b000;
        m_out = 3'b000; m_state = 3'd0;
        for (int i = 0; i < 3; i++) m_run[i] = 0;
        m_mode = M_IDLE; m_owner = 0; m_fire = 0; m_edge = 0;
    endtask

    task automatic model_edge(input logic [2:0] k);
        logic [2:0] sync, press;
        int d;
        sync  = ~m_s2;
        press = m_deb & ~m_debq;
        m_out = 3'b000;
        case (m_mode)
            M_IDLE: if (press != 0) begin
                m_owner = m_deb[2] ? 2 : (m_deb[0] ? 0 : 1);
                m_mode = M_FIRE; m_fire = m_edge; m_out[m_owner] = 1'b1;
            end
            M_FIRE: m_mode = (m_owner == 2) ? M_WAIT : M_HOLD;
            M_HOLD: begin
                if (!m_deb[m_owner]) begin
                    m_mode = (m_deb == 0) ? M_IDLE : M_WAIT;
                end else if (press[2] && m_owner != 2) begin
                    m_owner = 2; m_mode = M_FIRE; m_fire = m_edge; m_out[2] = 1'b1;
                end else begin
                    d = m_edge - m_fire;
                    if (d == R || (d > R && (d - R) % PD == 0)) m_out[m_owner] = 1'b1;
                end
            end
            default: if (m_deb == 0) m_mode = M_IDLE;
        endcase
        case (m_mode)
            M_IDLE: m_state = 3'd0;
            M_FIRE: m_state = 3'd1;
            M_WAIT: m_state = 3'd4;
            default: m_state = (m_edge - m_fire >= R) ? 3'd3 : 3'd2;
        endcase
        m_debq = m_deb;
        for (int i = 0; i < 3; i++) begin
            if (sync[i] != m_deb[i]) begin
                m_run[i]++;
                if (m_run[i] == D) begin
                    m_deb[i] = sync[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = k;
        m_edge++;
    endtask

    task automatic step(input logic [2:0] k);
        @(negedge clk);
        key_n = k;
        @(posedge clk);
        if (!reset_n) model_reset();
        else model_edge(key_n);
        #1;
        chk("pulses", 32'({speed_reset, speed_down, speed_up}), 32'(m_out));
        chk("state", 32'(state_dbg), 32'(m_state));
        if (speed_up)    c_up++;
        if (speed_down)  c_down++;
        if (speed_reset) c_rst++;
    endtask

    task automatic hold(input logic [2:0] k, input int n);
        for (int i = 0; i < n; i++) step(k);
    endtask

    task automatic clr();
        c_up = 0; c_down = 0; c_rst = 0;
    endtask

    initial begin
        model_reset();
        // Reset with every key held, then a single restore-default pulse.
        hold(3'b000, 3);
        reset_n = 1'b1;
        clr();
        hold(3'b000, 20);
        chk("rst_cnt", 32'(c_rst), 32'd1);
        chk("rst_up", 32'(c_up), 32'd0);
        hold(3'b111, 12);

        // Bounce on KEY0 then a short stable press.
        clr();
        for (int i = 0; i < 6; i++) hold((i % 2) ? 3'b111 : 3'b110, 2);
        chk("bounce_none", 32'(c_up), 32'd0);
        hold(3'b110, 8);
        hold(3'b111, 12);
        chk("bounce_one", 32'(c_up), 32'd1);

        // Long hold: P, P+10, then every 3 up to P+28.
        clr();
        hold(3'b110, 35);
        chk("hold_cnt", 32'(c_up), 32'd8);
        hold(3'b111, 7);
        clr();
        hold(3'b111, 15);
        chk("hold_after", 32'(c_up), 32'd0);

        // KEY0 and KEY2 together.
        clr();
        hold(3'b010, 30);
        hold(3'b111, 12);
        chk("simul_rst", 32'(c_rst), 32'd1);
        chk("simul_up", 32'(c_up), 32'd0);

        // Cross-press of the other step key.
        clr();
        hold(3'b110, 20);
        hold(3'b100, 10);
        hold(3'b101, 15);
        hold(3'b111, 15);
        chk("cross_down", 32'(c_down), 32'd0);
        clr();
        hold(3'b101, 9);
        hold(3'b111, 12);
        chk("repress_down", 32'(c_down), 32'd1);

        // Restore-default preempts a repeating KEY0.
        clr();
        hold(3'b110, 18);
        hold(3'b010, 15);
        hold(3'b111, 12);
        chk("preempt_rst", 32'(c_rst), 32'd1);

        // Async reset during the first auto-repeat pulse.
        hold(3'b110, 17);
        chk("pre_reset_pulse", 32'(speed_up), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("async_out", 32'({speed_reset, speed_down, speed_up}), 32'd0);
        chk("async_state", 32'(state_dbg), 32'd0);
        model_reset();
        hold(3'b110, 3);
        reset_n = 1'b1;
        clr();
        hold(3'b110, 9);
        hold(3'b111, 12);
        chk("reaccept", 32'(c_up), 32'd1);

        // Random key traffic with occasional bounce and reset.
        for (int s = 0; s < 150; s++) begin
            logic [2:0] k;
            k = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 39) == 0) begin
                reset_n = 1'b0;
                hold(k, 2);
                reset_n = 1'b1;
            end
            if ($urandom_range(0, 5) == 0) begin
                for (int b = 0; b < 4; b++) hold(3'($urandom_range(0, 7)), $urandom_range(1, 3));
            end
            hold(k, $urandom_range(1, 30));
        end
        hold(3'b111, 20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/speed_key_controller.md
# speed_key_controller

Turns the three raw DE1-SoC pushbuttons into clean, single-cycle speed commands for the playback-rate divisor register: synchronizes, debounces, arbitrates, and auto-repeats. Sits between `KEY[2:0]` and the divisor generator's `key_0`/`key_1`/`key_2` inputs. One press yields one step, and a held key steps at a controlled rate instead of once per 50 MHz clock.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a level change (10 ms @ 50 MHz); ≥2.
- `REPEAT_DELAY`, default 25000000: cycles from first pulse to first auto-repeat pulse (0.5 s); ≥2.
- `REPEAT_PERIOD`, default 5000000: cycles between subsequent auto-repeat pulses (0.1 s); ≥2.
- `CNT_W`, default 32: width of debounce and repeat counters; must hold the largest of the three parameters.
- `clk`  in  1  50 MHz system clock; sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `key_n`  in  3  raw active-low buttons: [0] faster, [1] slower, [2] restore default; asynchronous to `clk`.
- `speed_up`  out  1  one-cycle pulse; drives divisor generator `key_0`.
- `speed_down`  out  1  one-cycle pulse; drives `key_1`.
- `speed_reset`  out  1  one-cycle pulse; drives `key_2`.
- `state_dbg`  out  3  current FSM state encoding.

## Operation
- Per key: 2-flop synchronizer, inverted to active-high `sync[i]`, then a debouncer. The debounced level `deb[i]` takes the value of `sync[i]` once `sync[i]` has differed from `deb[i]` for DEBOUNCE_CYCLES consecutive cycles. The counter clears on any cycle where `sync[i] == deb[i]`.
- `press[i]` = rising edge of `deb[i]` (registered previous value).
- Priority: KEY2 > KEY0 > KEY1.
- FSM states:
  - IDLE → FIRE on any `press[i]`. Latches `owner` = highest-priority key with `deb` high.
  - FIRE: asserts `owner`'s output for exactly one cycle. If `owner` = KEY2, next state is WAIT_RELEASE; otherwise HOLD_DELAY with the repeat counter cleared.
  - HOLD_DELAY: counts REPEAT_DELAY cycles from the FIRE cycle, then issues a repeat pulse and moves to HOLD_REPEAT.
  - HOLD_REPEAT: issues a repeat pulse every REPEAT_PERIOD cycles.
  - WAIT_RELEASE: stays until all `deb` are low, then goes to IDLE.
- In HOLD_DELAY and HOLD_REPEAT:
  - On `deb[owner]` low: go to IDLE if all `deb` are low, else WAIT_RELEASE. No pulse on the release cycle.
  - On `press[2]` while owner is KEY0 or KEY1: preempts. `speed_reset` pulses the next cycle (via FIRE with `owner` = KEY2), then WAIT_RELEASE.
  - A press of the other step key is ignored. It cannot issue until all keys are released and it is pressed again.
- At most one of the three outputs is high in any cycle.

## Timing
- Reset (async assert, synchronous to `clk` deassert is not required): all outputs 0, FSM in IDLE, `deb` = 0, all counters 0, synchronizer flops = released.
- Press latency: for a raw press stable from edge 0, `sync` is high at edge 2, `deb` at edge 2+DEBOUNCE_CYCLES, and the pulse is high for the cycle after edge 3+DEBOUNCE_CYCLES.
- Release latency: 2+DEBOUNCE_CYCLES cycles to the `deb` fall.
- Repeat pulses land at FIRE+REPEAT_DELAY, then every +REPEAT_PERIOD thereafter, while held.
- All outputs are registered. There is no combinational path from `key_n` to any output.
- Reset mid-operation aborts any pending repeat. If a key is still held when reset releases, it is re-accepted as a fresh press after the full debounce latency and fires once.
- Counters saturate and never wrap, so no spurious pulse on overflow.

## Structure
- `speed_ctrl_pkg`: state enum (IDLE, FIRE, HOLD_DELAY, HOLD_REPEAT, WAIT_RELEASE), key index constants `KEY_UP=0`, `KEY_DOWN=1`, `KEY_RST=2`, and the owner typedef.
- Sub-module `key_debouncer` (synchronizer + debounce counter + `deb`/`press` outputs, parameterized by DEBOUNCE_CYCLES and CNT_W), instantiated three times.
- Top level holds the arbiter, FSM, repeat counter and output registers.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Reset: hold `reset_n`=0 with `key_n`=3'b000 → all outputs 0 and `state_dbg`=IDLE. After release, one `speed_reset` pulse follows 7 cycles later.
- Bounce: `key_n[0]` toggles every 2 cycles for 12 cycles, then held low from edge T → exactly one `speed_up`, high for the cycle after T+7. No pulse during the bounce.
- Hold: hold `key_n[0]` low for 30 cycles after the first pulse at P → `speed_up` at P, P+10, P+13, P+16 … P+28. No further pulse after release.
- Simultaneous: `key_n[0]` and `key_n[2]` fall on the same edge → single `speed_reset`, no `speed_up`, no repeats while held.
- Cross-press:
  - Hold KEY0 into repeat, then press KEY1 → no `speed_down`.
  - Release KEY0 while KEY1 is held → WAIT_RELEASE, no pulses.
  - Release KEY1, then re-press it → one `speed_down`.
- Preempt and async reset:
  - During KEY0 repeat, press KEY2 → `speed_reset` exactly once and repeats stop.
  - Assert `reset_n` mid-repeat → outputs drop to 0 the same cycle.
